// File: rtl/frigate_timing_pkg.sv
// Shared timing-subsystem types and defaults for the crystal oscillator controllers.
// The HSXO controller will reuse the window and threshold defaults.
package frigate_timing_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_MEASURE,
    ST_RUN,
    ST_STANDBY,
    ST_FAIL
  } lsxo_state_t;

  localparam int unsigned DEF_WINDOW_CYC      = 16384;
  localparam int unsigned DEF_MIN_EDGES       = 30;
  localparam int unsigned DEF_MAX_EDGES       = 36;
  localparam int unsigned DEF_GOOD_WINDOWS    = 4;
  localparam int unsigned DEF_TIMEOUT_WINDOWS = 1000;
  localparam int unsigned DEF_CNT_W           = 8;

  // Bits needed to hold values 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frigate_edge_sync.sv
// Two-flop synchronizer for an asynchronous input plus a registered rising-edge pulse.
module frigate_edge_sync (
  input  logic clk,
  input  logic resetb,
  input  logic din,
  output logic rise
);

  // [0],[1] are the synchronizer; [2] holds the previous synchronized value.
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync_pipe <= '0;
      rise      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[1:0], din};
      rise      <= sync_pipe[1] & ~sync_pipe[2];
    end
  end

endmodule

// File: rtl/frigate_lsxo_ctrl.sv
// 32.768 kHz crystal controller: qualifies the oscillator by counting edges per
// RC-clock window, reports ready/fail and keeps monitoring while running.
module frigate_lsxo_ctrl
  import frigate_timing_pkg::*;
#(
  parameter int unsigned WINDOW_CYC      = DEF_WINDOW_CYC,
  parameter int unsigned MIN_EDGES       = DEF_MIN_EDGES,
  parameter int unsigned MAX_EDGES       = DEF_MAX_EDGES,
  parameter int unsigned GOOD_WINDOWS    = DEF_GOOD_WINDOWS,
  parameter int unsigned TIMEOUT_WINDOWS = DEF_TIMEOUT_WINDOWS,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             req_on,
  input  logic             req_standby,
  input  logic             lsxo_dout,
  output logic             lsxo_ena,
  output logic             lsxo_standby,
  output logic             lsxo_ready,
  output logic             lsxo_fail,
  output logic [CNT_W-1:0] edge_count
);

  localparam int unsigned WIN_W  = cnt_width(WINDOW_CYC - 1);
  localparam int unsigned GOOD_W = cnt_width(GOOD_WINDOWS);
  localparam int unsigned TMO_W  = cnt_width(TIMEOUT_WINDOWS);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYC - 1);
  localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_EDGES);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_EDGES);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_WINDOWS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_WINDOWS - 1);

  lsxo_state_t       state, state_nxt;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt, edge_tot;
  logic [GOOD_W-1:0] good_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              rise, active, win_end, win_good;

  frigate_edge_sync u_sync (
    .clk    (clk),
    .resetb (resetb),
    .din    (lsxo_dout),
    .rise   (rise)
  );

  // The edge seen on the closing cycle still belongs to the window.
  always_comb begin
    active   = (state == ST_MEASURE) || (state == ST_RUN);
    win_end  = active && (win_cnt == WIN_LAST);
    edge_tot = (rise && (edge_cnt != '1)) ? edge_cnt + 1'b1 : edge_cnt;
    win_good = (edge_tot >= MIN_C) && (edge_tot <= MAX_C);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:     if (req_on) state_nxt = ST_MEASURE;
      ST_MEASURE: if (win_end) begin
                    if (win_good && (good_cnt == GOOD_LAST)) state_nxt = ST_RUN;
                    else if (tmo_cnt == TMO_LAST)            state_nxt = ST_FAIL;
                  end
      ST_RUN:     if (req_standby)              state_nxt = ST_STANDBY;
                  else if (win_end && !win_good) state_nxt = ST_MEASURE;
      ST_STANDBY: if (!req_standby) state_nxt = ST_MEASURE;
      ST_FAIL:    state_nxt = ST_FAIL;
      default:    state_nxt = ST_OFF;
    endcase
    if (!req_on) state_nxt = ST_OFF;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_OFF;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      win_cnt    <= '0;
      edge_cnt   <= '0;
      edge_count <= '0;
    end else begin
      if (!active || win_end) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else begin
        win_cnt  <= win_cnt + 1'b1;
        edge_cnt <= edge_tot;
      end
      if (win_end) edge_count <= edge_tot;
    end
  end

  // Held at zero outside MEASURE so every entry re-qualifies from scratch.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      good_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (state != ST_MEASURE) begin
      good_cnt <= '0;
      tmo_cnt  <= '0;
    end else if (win_end) begin
      good_cnt <= win_good ? good_cnt + 1'b1 : '0;
      tmo_cnt  <= tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      lsxo_ena     <= 1'b0;
      lsxo_standby <= 1'b0;
      lsxo_ready   <= 1'b0;
      lsxo_fail    <= 1'b0;
    end else begin
      lsxo_ena     <= (state_nxt == ST_MEASURE) || (state_nxt == ST_RUN) ||
                      (state_nxt == ST_STANDBY);
      lsxo_standby <= (state_nxt == ST_STANDBY);
      lsxo_ready   <= (state_nxt == ST_RUN);
      lsxo_fail    <= (state_nxt == ST_FAIL);
    end
  end

endmodule
